// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and byte counts.
// Also holds the helper that maps an access size to its base lane mask.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  // IDLE accept | ACC0 first word | ACC1 following word | RESP completion pulse
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC0 = 2'd1;
  localparam logic [1:0] ST_ACC1 = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [2:0] NBYTES_BYTE = 3'd1;
  localparam logic [2:0] NBYTES_HALF = 3'd2;
  localparam logic [2:0] NBYTES_WORD = 3'd4;

  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return NBYTES_BYTE;
      SIZE_HALF: return NBYTES_HALF;
      SIZE_WORD: return NBYTES_WORD;
      default:   return 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] base_lanes(input logic [1:0] size);
    logic [4:0] m;
    m = (5'd1 << size_nbytes(size)) - 5'd1;
    return m[3:0];
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane-enable, store rotation, load byte merge and sign/zero extension.
// Load bytes are rotated right by the offset so both words land in address order.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_phase,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_data_prev,
  output logic [3:0]  o_lanes,
  output logic        o_split,
  output logic [31:0] o_wdata_rot,
  output logic [31:0] o_data_merged,
  output logic [31:0] o_data_ext
);

  logic [7:0]  w_lanes8;
  logic [3:0]  w_byte_mask;
  logic [31:0] w_rdata_rot;

  assign w_lanes8 = {4'b0000, base_lanes(i_size)} << i_offset;
  assign o_split  = |w_lanes8[7:4];
  assign o_lanes  = i_phase ? w_lanes8[7:4] : w_lanes8[3:0];

  always_comb begin
    o_wdata_rot = i_wdata;
    w_rdata_rot = i_rdata;
    w_byte_mask = o_lanes;
    case (i_offset)
      2'd1: begin
        o_wdata_rot = {i_wdata[23:0], i_wdata[31:24]};
        w_rdata_rot = {i_rdata[7:0], i_rdata[31:8]};
        w_byte_mask = {o_lanes[0], o_lanes[3:1]};
      end
      2'd2: begin
        o_wdata_rot = {i_wdata[15:0], i_wdata[31:16]};
        w_rdata_rot = {i_rdata[15:0], i_rdata[31:16]};
        w_byte_mask = {o_lanes[1:0], o_lanes[3:2]};
      end
      2'd3: begin
        o_wdata_rot = {i_wdata[7:0], i_wdata[31:8]};
        w_rdata_rot = {i_rdata[23:0], i_rdata[31:24]};
        w_byte_mask = {o_lanes[2:0], o_lanes[3]};
      end
      default: ;
    endcase
  end

  always_comb begin
    o_data_merged = i_data_prev;
    for (int i = 0; i < 4; i++) begin
      if (w_byte_mask[i]) o_data_merged[8*i +: 8] = w_rdata_rot[8*i +: 8];
    end
  end

  always_comb begin
    o_data_ext = o_data_merged;
    case (i_size)
      SIZE_BYTE: o_data_ext = {{24{o_data_merged[7]  & ~i_unsigned}}, o_data_merged[7:0]};
      SIZE_HALF: o_data_ext = {{16{o_data_merged[15] & ~i_unsigned}}, o_data_merged[15:0]};
      default:   o_data_ext = o_data_merged;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit in front of a word RAM; misaligned accesses
// that cross a word boundary take a second access cycle (ACC1).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wenable,
  input  logic [31:0]           mem_rdata
);

  logic [1:0]            r_state;
  logic                  r_write;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_data;
  logic [31:0]           r_resp_rdata;
  logic                  r_resp_error;

  logic                  w_phase;
  logic                  w_in_acc;
  logic                  w_split;
  logic [3:0]            w_lanes;
  logic [31:0]           w_wdata_rot;
  logic [31:0]           w_data_merged;
  logic [31:0]           w_data_ext;
  logic [ADDR_WIDTH-3:0] w_idx_next;
  logic                  w_unused_addr_hi;

  lsu_align u_align (
    .i_size        (r_size),
    .i_offset      (r_addr[1:0]),
    .i_phase       (w_phase),
    .i_unsigned    (r_unsigned),
    .i_wdata       (r_wdata),
    .i_rdata       (mem_rdata),
    .i_data_prev   (r_data),
    .o_lanes       (w_lanes),
    .o_split       (w_split),
    .o_wdata_rot   (w_wdata_rot),
    .o_data_merged (w_data_merged),
    .o_data_ext    (w_data_ext)
  );

  assign w_phase          = (r_state == ST_ACC1);
  assign w_in_acc         = (r_state == ST_ACC0) || (r_state == ST_ACC1);
  assign w_idx_next       = r_addr[ADDR_WIDTH-1:2] + {{(ADDR_WIDTH-3){1'b0}}, 1'b1};
  assign w_unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_error = r_resp_error;

  // Memory port is quiet (all zero) outside the access states.
  always_comb begin
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wenable = 4'b0000;
    if (w_in_acc) begin
      mem_addr  = w_phase ? {w_idx_next, 2'b00} : {r_addr[ADDR_WIDTH-1:2], 2'b00};
      mem_wdata = w_wdata_rot;
      if (r_write) mem_wenable = w_lanes;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_write      <= 1'b0;
      r_size       <= SIZE_BYTE;
      r_unsigned   <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_data       <= '0;
      r_resp_rdata <= '0;
      r_resp_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_write    <= req_write;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr[ADDR_WIDTH-1:0];
            r_wdata    <= req_wdata;
            r_data     <= '0;
            if (req_size == SIZE_RSVD) begin
              r_state      <= ST_RESP;
              r_resp_error <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_state <= ST_ACC0;
            end
          end
        end
        ST_ACC0, ST_ACC1: begin
          if (!r_write) r_data <= w_data_merged;
          if ((r_state == ST_ACC0) && w_split) begin
            r_state <= ST_ACC1;
          end else begin
            r_state      <= ST_RESP;
            r_resp_error <= 1'b0;
            r_resp_rdata <= r_write ? 32'd0 : w_data_ext;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: load_store_unit paired with a dual-port word RAM model
// (port 1 for the DUT, port 2 for bench preload/inspection).
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wenable;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:1023];
  logic        p2_we;
  logic [9:0]  p2_addr;
  logic [31:0] p2_wdata;
  logic [31:0] p2_rdata;
  logic        unused_mem_lsb;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat;
  int          we_cnt;
  logic [31:0] rd;
  logic        er;
  logic [11:0] tr_addr [0:8];
  logic [3:0]  tr_we   [0:8];
  logic [31:0] tr_wd   [0:8];
  logic [31:0] bd;

  load_store_unit #(.ADDR_WIDTH(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wenable  (mem_wenable),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_wenable[i]) ram[mem_addr[11:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
    if (p2_we) ram[p2_addr] <= p2_wdata;
  end

  assign mem_rdata      = ram[mem_addr[11:2]];
  assign p2_rdata       = ram[p2_addr];
  assign unused_mem_lsb = ^mem_addr[1:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic bd_write(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    p2_addr  = a;
    p2_wdata = d;
    p2_we    = 1'b1;
    @(negedge clk);
    p2_we    = 1'b0;
  endtask

  task automatic bd_read(input logic [9:0] a, output logic [31:0] d);
    p2_addr = a;
    #1;
    d = p2_rdata;
  endtask

  // Issue one request, trace the memory port per cycle, return once back in IDLE.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat       = 0;
    we_cnt    = 0;
    rd        = 32'hxxxx_xxxx;
    er        = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      tr_addr[k] = mem_addr;
      tr_we[k]   = mem_wenable;
      tr_wd[k]   = mem_wdata;
      if (mem_wenable != 4'b0000) we_cnt++;
      if (resp_valid) begin
        lat = k;
        rd  = resp_rdata;
        er  = resp_error;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    p2_we        = 1'b0;
    p2_addr      = 10'd0;
    p2_wdata     = 32'd0;

    #3;
    chk("rst_req_ready",   32'(req_ready),   32'd1);
    chk("rst_resp_valid",  32'(resp_valid),  32'd0);
    chk("rst_resp_rdata",  resp_rdata,       32'd0);
    chk("rst_resp_error",  32'(resp_error),  32'd0);
    chk("rst_mem_wenable", 32'(mem_wenable), 32'd0);
    chk("rst_mem_addr",    32'(mem_addr),    32'd0);
    chk("rst_mem_wdata",   mem_wdata,        32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // aligned word store then load
    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    chk("sw_latency",    32'(lat),        32'd2);
    chk("sw_addr",       32'(tr_addr[1]), 32'h100);
    chk("sw_wenable",    32'(tr_we[1]),   32'hF);
    chk("sw_we_cycles",  32'(we_cnt),     32'd1);
    chk("sw_rdata_zero", rd,              32'd0);
    bd_read(10'h040, bd);
    chk("sw_ram",        bd,              32'hDEADBEEF);

    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    chk("lw_latency",   32'(lat),    32'd2);
    chk("lw_rdata",     rd,          32'hDEADBEEF);
    chk("lw_no_write",  32'(we_cnt), 32'd0);

    // byte store, signed and unsigned byte loads
    do_req(1'b1, 2'd0, 1'b0, 32'h103, 32'h00000080);
    chk("sb_wenable", 32'(tr_we[1]), 32'h8);
    chk("sb_wdata",   tr_wd[1],      32'h80000000);
    bd_read(10'h040, bd);
    chk("sb_ram",     bd,            32'h80ADBEEF);

    do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'd0);
    chk("lb_signed",   rd, 32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'd0);
    chk("lb_unsigned", rd, 32'h00000080);

    // half store split across 0x0FC / 0x100
    do_req(1'b1, 2'd1, 1'b0, 32'h0FF, 32'h00001234);
    chk("sh_latency", 32'(lat),        32'd3);
    chk("sh_addr0",   32'(tr_addr[1]), 32'h0FC);
    chk("sh_we0",     32'(tr_we[1]),   32'h8);
    chk("sh_addr1",   32'(tr_addr[2]), 32'h100);
    chk("sh_we1",     32'(tr_we[2]),   32'h1);
    chk("sh_wdata",   tr_wd[1],        32'h34000012);
    bd_read(10'h040, bd);
    chk("sh_ram_hi",  bd,              32'h80ADBE12);

    do_req(1'b0, 2'd1, 1'b0, 32'h0FF, 32'd0);
    chk("lh_split_latency", 32'(lat), 32'd3);
    chk("lh_split_rdata",   rd,       32'h00001234);

    do_req(1'b0, 2'd1, 1'b0, 32'h102, 32'd0);
    chk("lh_neg_latency", 32'(lat), 32'd2);
    chk("lh_neg_rdata",   rd,       32'hFFFF80AD);

    // word store crossing the top of the address space
    do_req(1'b1, 2'd2, 1'b0, 32'hFFE, 32'hCAFEF00D);
    chk("wrap_latency", 32'(lat),        32'd3);
    chk("wrap_addr0",   32'(tr_addr[1]), 32'hFFC);
    chk("wrap_we0",     32'(tr_we[1]),   32'hC);
    chk("wrap_addr1",   32'(tr_addr[2]), 32'h000);
    chk("wrap_we1",     32'(tr_we[2]),   32'h3);
    chk("wrap_wdata",   tr_wd[1],        32'hF00DCAFE);

    do_req(1'b0, 2'd2, 1'b0, 32'hFFE, 32'd0);
    chk("wrap_load", rd, 32'hCAFEF00D);

    // upper address bits ignored
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_1100, 32'd0);
    chk("trunc_load", rd, 32'h80ADBE12);

    // reserved size
    do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'd0);
    chk("rsvd_latency",  32'(lat),        32'd1);
    chk("rsvd_error",    32'(er),         32'd1);
    chk("rsvd_rdata",    rd,              32'd0);
    chk("rsvd_no_write", 32'(we_cnt),     32'd0);
    chk("rsvd_err_hold", 32'(resp_error), 32'd1);

    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    chk("err_cleared", 32'(er), 32'd0);

    // reset in ACC0 of a split store
    bd_write(10'h041, 32'h11111111);
    bd_write(10'h042, 32'h22222222);
    @(negedge clk);
    req_valid    = 1'b1;
    req_write    = 1'b1;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    req_addr     = 32'h106;
    req_wdata    = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("abort_acc0_we", 32'(mem_wenable), 32'hC);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_ready",   32'(req_ready),   32'd1);
    chk("abort_we",      32'(mem_wenable), 32'd0);
    chk("abort_valid",   32'(resp_valid),  32'd0);
    chk("abort_addr",    32'(mem_addr),    32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bd_read(10'h042, bd);
    chk("abort_word2", bd, 32'h22222222);
    bd_read(10'h041, bd);
    chk("abort_word1", bd, 32'h11111111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter ADDR_WIDTH, default 12: byte-address width of the attached word RAM.
REQ-003 Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- req_valid  in  1  CPU access request
- req_ready  out  1  block can accept a request
- req_write  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved
- req_unsigned  in  1  zero-extend load result
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data, 0 for stores
- resp_error  out  1  reserved size in completed request
- mem_addr  out  ADDR_WIDTH  RAM port-1 address, always word-aligned
- mem_wdata  out  32  RAM write data, lane-positioned
- mem_wenable  out  4  RAM per-lane write enables
- mem_rdata  in  32  RAM port-1 read data, combinational from mem_addr

Function
REQ-004 The block SHALL use states IDLE, ACC0, ACC1 and RESP, with req_ready = 1 only in IDLE.
REQ-005 On req_valid & req_ready, the block SHALL latch all req_* fields and go to ACC0, or go to RESP with resp_error=1 and no memory access when req_size=3.
REQ-006 With offset o = addr[1:0] and byte count n = 1/2/4: ACC0 SHALL drive mem_addr = {addr[ADDR_WIDTH-1:2],2'b00}, with lanes o..min(o+n,4)-1 active.
REQ-007 If o+n > 4, ACC0 SHALL be followed by ACC1, which drives the next word address (+4, wrapping modulo 2^ADDR_WIDTH) with lanes 0..o+n-5 active; otherwise ACC0 SHALL go directly to RESP.
REQ-008 For stores, mem_wdata SHALL equal req_wdata rotated left by 8*o, and mem_wenable SHALL equal the active lanes in ACC0/ACC1 and 4'b0000 in every other state.
REQ-009 For loads, the block SHALL capture the active lanes of mem_rdata at the end of ACC0/ACC1, and mem_wenable SHALL stay 0.
REQ-010 Captured bytes SHALL be reassembled in address order, then sign-extended from bit 7 (byte) or bit 15 (half) unless req_unsigned=1; words are not extended.
REQ-011 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE; resp_rdata and resp_error SHALL hold until the next RESP.
REQ-012 Latency from accept edge to resp_valid SHALL be: aligned 2 cycles, split 3 cycles, reserved 1 cycle.
REQ-013 A request is accepted on the same edge that req_ready is high; back-to-back requests SHALL incur one IDLE cycle between responses.
REQ-014 Addresses SHALL be truncated to ADDR_WIDTH bits, and out-of-range upper bits SHALL be ignored.

Reset
REQ-015 Asserting rst_n low SHALL asynchronously force: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_wenable=0, mem_addr=0, mem_wdata=0.
REQ-016 Reset during ACC0/ACC1 SHALL abort the access with no further write; a store split across two words may leave only the first word updated.

Structure
REQ-017 Size encodings, state encodings and byte-count constants SHALL live in shared package lsu_pkg.
REQ-018 Lane-enable, rotation and extension logic SHALL be a combinational sub-module lsu_align, instantiated once.

Verification
REQ-019 The bench SHALL pair the block with the dual-port word RAM model and cover:
- Store word 0xDEADBEEF @0x100 -> mem_wenable 4'b1111 once, mem_addr 0x100; load word @0x100 -> resp_rdata 0xDEADBEEF, 2 cycles after accept.
- Store byte 0x80 @0x103, signed load byte @0x103 -> 0xFFFFFF80; unsigned load byte @0x103 -> 0x00000080.
- Store half 0x1234 @0x0FF -> ACC0 lanes 4'b1000 @0x0FC, ACC1 lanes 4'b0001 @0x100; load half @0x0FF -> 0x00001234, 3 cycles after accept.
- Word store @0xFFE (ADDR_WIDTH=12) -> second access wraps to mem_addr 0x000, lanes 4'b0011.
- req_size=3 -> resp_valid after 1 cycle with resp_error=1, no mem_wenable activity.
- rst_n low during ACC0 of a split store -> immediate IDLE, mem_wenable 0, second word unchanged, req_ready=1.
